// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner: one active-low row at a time, synchronized columns,
// press/release debounce, single-cycle key_valid pulse with a latched key code.
module keypad_scan_debounce #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int SCAN_DWELL      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] matricial_col,
  output logic [3:0] matricial_lin,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int DW = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DWELL - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, VALID, WAIT_RELEASE} state_t;

  state_t          state, state_nx;
  logic [3:0]      col_meta, col_s;
  logic [1:0]      row, row_nx;
  logic [DW-1:0]   dwell, dwell_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [3:0]      mask, mask_nx;
  logic [3:0]      code_nx;

  function automatic logic one_cold(input logic [3:0] v);
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_cold = 1'b1;
      default:                            one_cold = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] map_code(input logic [1:0] r, input logic [3:0] m);
    logic [1:0] c;
    case (m)
      4'b1110: c = 2'd0;
      4'b1101: c = 2'd1;
      4'b1011: c = 2'd2;
      default: c = 2'd3;
    endcase
    case ({r, c})
      4'd0:  map_code = 4'h1;
      4'd1:  map_code = 4'h2;
      4'd2:  map_code = 4'h3;
      4'd3:  map_code = 4'hA;
      4'd4:  map_code = 4'h4;
      4'd5:  map_code = 4'h5;
      4'd6:  map_code = 4'h6;
      4'd7:  map_code = 4'hB;
      4'd8:  map_code = 4'h7;
      4'd9:  map_code = 4'h8;
      4'd10: map_code = 4'h9;
      4'd11: map_code = 4'hC;
      4'd12: map_code = 4'hF;
      4'd13: map_code = 4'h0;
      4'd14: map_code = 4'hD;
      default: map_code = 4'hE;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta <= '1;
      col_s    <= '1;
    end else begin
      col_meta <= matricial_col;
      col_s    <= col_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= SCAN;
      row      <= '0;
      dwell    <= '0;
      cnt      <= '0;
      mask     <= '1;
      key_code <= '0;
    end else begin
      state    <= state_nx;
      row      <= row_nx;
      dwell    <= dwell_nx;
      cnt      <= cnt_nx;
      mask     <= mask_nx;
      key_code <= code_nx;
    end
  end

  // Both debounce phases need DEBOUNCE_CYCLES consecutive qualifying cycles (count 0..N-1).
  always_comb begin
    state_nx = state;
    row_nx   = row;
    dwell_nx = dwell;
    cnt_nx   = cnt;
    mask_nx  = mask;
    code_nx  = key_code;
    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_nx = '0;
          if (one_cold(col_s)) begin
            state_nx = DEBOUNCE;
            mask_nx  = col_s;
            cnt_nx   = '0;
          end else begin
            row_nx = row + 1'b1;
          end
        end else begin
          dwell_nx = dwell + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (col_s == mask) begin
          if (cnt == DEB_LAST) begin
            state_nx = VALID;
            code_nx  = map_code(row, mask);
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end else begin
          state_nx = SCAN;
          dwell_nx = '0;
        end
      end
      VALID: begin
        state_nx = WAIT_RELEASE;
        cnt_nx   = '0;
      end
      WAIT_RELEASE: begin
        if (col_s == 4'hF) begin
          if (cnt == DEB_LAST) begin
            state_nx = SCAN;
            row_nx   = row + 1'b1;
            dwell_nx = '0;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end else begin
          cnt_nx = '0;
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  assign key_valid = (state == VALID);

  always_comb begin
    case (row)
      2'd0:    matricial_lin = 4'b1110;
      2'd1:    matricial_lin = 4'b1101;
      2'd2:    matricial_lin = 4'b1011;
      default: matricial_lin = 4'b0111;
    endcase
  end

endmodule
